// File: rtl/debug_reg_dump_pkg.sv
// Shared types and constants for the debug register dump streamer.
// Holds the dump FSM state encoding and the processor debug-port geometry.
package debug_reg_dump_pkg;

    // CAPTURE is a label for the final SETTLE cycle. It is never entered on its own.
    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        SETTLE,
        CAPTURE,
        CSUM,
        DONE
    } dump_state_e;

    localparam int DBG_SEL_W  = 5;
    localparam int DBG_DATA_W = 32;

    localparam int IDX_PC       = 0;
    localparam int IDX_REG_BASE = 1;

endpackage

// File: rtl/debug_reg_dump.sv
// Sweeps the processor register file through its debug port and streams PC + registers
// as one valid/ready frame. Optional trailing XOR checksum word: DEBUG_DUMP_CHECKSUM_EN.
module debug_reg_dump
    import debug_reg_dump_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDX_W         = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DBG_DATA_W-1:0] PC,
    input  logic [DBG_DATA_W-1:0] Debug_out,
    output logic [DBG_SEL_W-1:0]  Debug_source_select,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DBG_DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]      m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT     = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST    = IDX_W'(IDX_PC);
    localparam logic [IDX_W-1:0] IDX_LAST_REG = IDX_W'(IDX_REG_BASE + NUM_REGS - 1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] IDX_CHECKSUM = IDX_W'(IDX_REG_BASE + NUM_REGS);
`endif

    dump_state_e           r_state;
    logic [DBG_DATA_W-1:0] r_data;
    logic [IDX_W-1:0]      r_index;
    logic [DBG_SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]      r_cnt;

    dump_state_e           w_state_nxt;
    logic [DBG_DATA_W-1:0] w_data_nxt;
    logic [IDX_W-1:0]      w_index_nxt;
    logic [DBG_SEL_W-1:0]  w_sel_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_handshake;
    logic                  w_more_regs;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DBG_DATA_W-1:0] r_csum;
    logic [DBG_DATA_W-1:0] w_csum_nxt;
`endif

    assign w_handshake = m_valid & m_ready;
    assign w_more_regs = (r_index < IDX_LAST_REG);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        w_csum_nxt  = r_csum;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_data_nxt  = PC;
                    w_index_nxt = IDX_FIRST;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    w_csum_nxt  = PC;
`endif
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_handshake) begin
                    if (w_more_regs) begin
                        // Word k carries register k-1, so the next register number equals k.
                        w_sel_nxt   = r_index[DBG_SEL_W-1:0];
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = SETTLE;
                    end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        w_data_nxt  = r_csum;
                        w_index_nxt = IDX_CHECKSUM;
                        w_state_nxt = CSUM;
`else
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
            SETTLE, CAPTURE: begin
                if (r_cnt == '0) begin
                    w_data_nxt  = Debug_out;
                    w_index_nxt = r_index + IDX_W'(1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ Debug_out;
`endif
                    w_state_nxt = EMIT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            CSUM: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                if (w_handshake) begin
                    w_state_nxt = DONE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_index <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            r_csum  <= w_csum_nxt;
`endif
        end
    end

    assign m_valid             = (r_state == EMIT) || (r_state == CSUM);
    assign m_data              = r_data;
    assign m_index             = r_index;
    assign Debug_source_select = r_sel;
    assign busy                = (r_state != IDLE);
    assign done                = (r_state == DONE);

`ifdef DEBUG_DUMP_CHECKSUM_EN
    assign m_last = (r_state == CSUM);
`else
    assign m_last = (r_state == EMIT) && (r_index == IDX_LAST_REG);
`endif

endmodule

// File: tb/tb_debug_reg_dump.sv
// Directed bench for debug_reg_dump: reset, full frame, backpressure, 3-cycle settle,
// start-while-busy and reset abort. Honours DEBUG_DUMP_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_debug_reg_dump;

    localparam int NREG  = 32;
    localparam int IDX_W = 6;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = NREG + 2;
`else
    localparam int FRAME_LEN = NREG + 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             a_start, a_valid, a_ready, a_last, a_busy, a_done;
    logic [31:0]      a_pc, a_dbg, a_data;
    logic [4:0]       a_sel;
    logic [IDX_W-1:0] a_index;
    logic             b_start, b_valid, b_ready, b_last, b_busy, b_done;
    logic [31:0]      b_pc, b_dbg, b_data;
    logic [4:0]       b_sel;
    logic [IDX_W-1:0] b_index;

    // Register model A: Debug_out follows the select combinationally.
    assign a_dbg = 32'h100 + {27'd0, a_sel};

    // Register model B: Debug_out is garbage until the third cycle after a select change.
    logic [4:0] b_sel_q = '0;
    int         b_age   = 7;
    always @(posedge clk) begin
        if (b_sel != b_sel_q) begin
            b_sel_q <= b_sel;
            b_age   <= 1;
        end else if (b_age < 7) begin
            b_age <= b_age + 1;
        end
    end
    assign b_dbg = (b_sel == b_sel_q && b_age >= 2) ? (32'h200 + {27'd0, b_sel}) : 32'hDEAD_BEEF;

    debug_reg_dump #(.NUM_REGS(NREG), .SETTLE_CYCLES(1), .IDX_W(IDX_W)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .PC(a_pc), .Debug_out(a_dbg),
        .Debug_source_select(a_sel), .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
        .m_index(a_index), .m_last(a_last), .busy(a_busy), .done(a_done)
    );

    debug_reg_dump #(.NUM_REGS(NREG), .SETTLE_CYCLES(3), .IDX_W(IDX_W)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .PC(b_pc), .Debug_out(b_dbg),
        .Debug_source_select(b_sel), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
        .m_index(b_index), .m_last(b_last), .busy(b_busy), .done(b_done)
    );

    int n_tests;
    int n_fail;

    logic [31:0]      cap_data [64];
    logic [IDX_W-1:0] cap_idx  [64];
    logic             cap_last [64];
    int               cap_n;
    int               last_cyc;
    int               done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Records frame A from the current negedge until done; optionally stalls 4 cycles at drop_idx.
    task automatic collect_a(input int drop_idx);
        bit seen_done = 1'b0;
        bit dropped   = 1'b0;
        cap_n    = 0;
        last_cyc = -1;
        done_cyc = -1;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (a_valid && int'(a_index) == drop_idx && !dropped) begin
                dropped = 1'b1;
                a_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_valid", 32'(a_valid), 32'd1);
                    check("bp_data", a_data, 32'h100 + 32'(drop_idx - 1));
                    check("bp_index", 32'(a_index), 32'(drop_idx));
                    check("bp_sel", 32'(a_sel), 32'(drop_idx - 1));
                end
                a_ready = 1'b1;
            end
            if (a_valid && a_ready) begin
                if (cap_n < 64) begin
                    cap_data[cap_n] = a_data;
                    cap_idx[cap_n]  = a_index;
                    cap_last[cap_n] = a_last;
                end
                cap_n++;
                last_cyc = cyc;
            end
            if (a_done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("a_frame_done", 32'(seen_done), 32'd1);
        check("a_done_gap", 32'(done_cyc - last_cyc), 32'd1);
        if (drop_idx >= 0) check("bp_seen", 32'(dropped), 32'd1);
    endtask

    task automatic collect_b();
        bit seen_done = 1'b0;
        cap_n = 0;
        for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
            if (b_valid && b_ready) begin
                if (cap_n < 64) begin
                    cap_data[cap_n] = b_data;
                    cap_idx[cap_n]  = b_index;
                    cap_last[cap_n] = b_last;
                end
                cap_n++;
            end
            if (b_done) seen_done = 1'b1;
            else @(negedge clk);
        end
        check("b_frame_done", 32'(seen_done), 32'd1);
    endtask

    // Compares the captured frame against PC, base+reg and the XOR checksum.
    task automatic check_frame(input string tag, input logic [31:0] pc, input logic [31:0] base);
        logic [31:0] csum = pc;
        logic [31:0] exp_d;
        for (int i = 0; i < NREG; i++) csum = csum ^ (base + 32'(i));
        check({tag, "_len"}, 32'(cap_n), 32'(FRAME_LEN));
        for (int k = 0; k < cap_n && k < 64; k++) begin
            exp_d = (k == 0) ? pc : (k <= NREG) ? base + 32'(k - 1) : csum;
            check($sformatf("%s_data%0d", tag, k), cap_data[k], exp_d);
            check($sformatf("%s_idx%0d", tag, k), 32'(cap_idx[k]), 32'(k));
            check($sformatf("%s_last%0d", tag, k), 32'(cap_last[k]), 32'(k == FRAME_LEN - 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held two cycles with start asserted.
        reset   = 1'b1;
        a_start = 1'b1;
        b_start = 1'b1;
        a_pc    = 32'hFFFF_0000;
        b_pc    = 32'hFFFF_0000;
        a_ready = 1'b1;
        b_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_sel", 32'(a_sel), 32'd0);
        check("rst_index", 32'(a_index), 32'd0);
        check("rst_data", a_data, 32'd0);
        check("rst_last", 32'(a_last), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        reset   = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(a_valid), 32'd0);
        check("idle_busy", 32'(a_busy), 32'd0);

        // Full frame, ready always high.
        a_pc    = 32'h0000_0040;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("lat_valid", 32'(a_valid), 32'd1);
        check("lat_busy", 32'(a_busy), 32'd1);
        collect_a(-1);
        check_frame("full", 32'h40, 32'h100);
        check("full_w0", cap_data[0], 32'h0000_0040);
        check("full_w6", cap_data[6], 32'h0000_0105);
        check("full_w32", cap_data[32], 32'h0000_011F);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        check("full_last32", 32'(cap_last[32]), 32'd0);
        check("full_w33", cap_data[33], 32'h0000_0040);
        check("full_last33", 32'(cap_last[33]), 32'd1);
`else
        check("full_last32", 32'(cap_last[32]), 32'd1);
`endif
        // start during DONE is ignored.
        check("done_busy", 32'(a_busy), 32'd1);
        a_pc    = 32'hFFFF_FFFF;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("done_once", 32'(a_done), 32'd0);
        check("post_done_busy", 32'(a_busy), 32'd0);
        check("post_done_sel", 32'(a_sel), 32'd31);
        @(negedge clk);
        check("done_start_ignored", 32'(a_valid), 32'd0);

        // Backpressure for 4 cycles while index 8 is offered.
        a_pc    = 32'h0000_0040;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        collect_a(8);
        check("bp_len", 32'(cap_n), 32'(FRAME_LEN));
        check("bp_w8", cap_data[8], 32'h0000_0107);
        check("bp_w9", cap_data[9], 32'h0000_0108);
        check("bp_i9", 32'(cap_idx[9]), 32'd9);
        @(negedge clk);

        // Three-cycle settle against a slow register model.
        b_pc    = 32'hCAFE_0001;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        collect_b();
        check_frame("settle3", 32'hCAFE_0001, 32'h200);
        @(negedge clk);

        // Start while busy is ignored, then reset at index 10 aborts the frame.
        a_pc    = 32'h0000_1234;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 100 && !(a_valid && a_index == 6'd3); c++) @(negedge clk);
        check("busy_at3", 32'(a_index), 32'd3);
        a_pc    = 32'h0000_0BAD;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("busy_start_idx", 32'(a_index), 32'd3);
        check("busy_start_data", a_data, 32'h0000_0102);
        for (int c = 0; c < 100 && !(a_valid && a_index == 6'd10); c++) @(negedge clk);
        check("abort_at10", 32'(a_index), 32'd10);
        check("abort_data10", a_data, 32'h0000_0109);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_valid", 32'(a_valid), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_index", 32'(a_index), 32'd0);
        check("abort_sel", 32'(a_sel), 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(a_done), 32'd0);
        check("abort_idle", 32'(a_valid), 32'd0);

        a_pc    = 32'h5555_AAAA;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("restart_valid", 32'(a_valid), 32'd1);
        check("restart_index", 32'(a_index), 32'd0);
        check("restart_data", a_data, 32'h5555_AAAA);
        collect_a(-1);
        check_frame("restart", 32'h5555_AAAA, 32'h100);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
